// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART register block: TX/RX byte FIFOs behind a data and a status register.
// Define UART_LOOPBACK_EN to route bytes launched by the TX FSM back into the RX FIFO.
module uart_mmio_bridge #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] DATA_ADDR  = 32'hbfd003f8,
  parameter logic [31:0] STAT_ADDR  = 32'hbfd003fc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_we_n_i,
  input  logic        mem_oe_n_i,
  input  logic [3:0]  mem_be_n_i,
  input  logic        mem_ce_n_i,
  input  logic        stall_i,
  output logic [31:0] uart_rdata_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_ready_i,
  output logic        rx_clear_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_GUARD} tx_state_e;

  // Request decode
  logic rd_data, rd_stat, wr_data, act;
  assign act     = ~stall_i;
  assign rd_data = ~mem_ce_n_i & ~mem_oe_n_i & (mem_addr_i == DATA_ADDR);
  assign rd_stat = ~mem_ce_n_i & ~mem_oe_n_i & (mem_addr_i == STAT_ADDR);
  assign wr_data = ~mem_ce_n_i & ~mem_we_n_i & ~mem_be_n_i[0] & (mem_addr_i == DATA_ADDR);

  logic unused_bits;
  `ifdef UART_LOOPBACK_EN
  assign unused_bits = ^{mem_data_i[31:8], mem_be_n_i[3:1], rx_data_i, rx_ready_i};
  `else
  assign unused_bits = ^{mem_data_i[31:8], mem_be_n_i[3:1]};
  `endif

  // TX FIFO and launch FSM
  logic [7:0]       tx_mem_q [FIFO_DEPTH];
  logic [7:0]       tx_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  tx_state_e        state_q, state_d;
  logic             tx_full, tx_empty, tx_push, tx_pop;
  `ifdef UART_LOOPBACK_EN
  logic             lb_push;
  `endif

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = wr_data & act & ~tx_full;
  assign tx_pop   = (state_q == TX_IDLE) & ~tx_empty & ~tx_busy_i;

  // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latch is inferred.
  always_comb begin
    tx_mem_d  = tx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wptr_q] = mem_data_i[7:0];
      tx_wptr_d           = tx_wptr_q + PTR_W'(1);
    end
    if (tx_pop) tx_rptr_d = tx_rptr_q + PTR_W'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_W'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_W'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_o = 1'b0;
    `ifdef UART_LOOPBACK_EN
    lb_push    = 1'b0;
    `endif
    case (state_q)
      TX_IDLE: begin
        if (tx_pop) begin
          state_d   = TX_START;
          tx_data_d = tx_mem_q[tx_rptr_q];
        end
      end
      TX_START: begin
        state_d = TX_GUARD;
        `ifdef UART_LOOPBACK_EN
        lb_push = 1'b1;
        `else
        tx_start_o = 1'b1;
        `endif
      end
      TX_GUARD: state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  assign tx_data_o = tx_data_q;

  // RX FIFO, fed by the receiver handshake or by the loopback path
  logic [7:0]       rx_mem_q [FIFO_DEPTH];
  logic [7:0]       rx_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             rx_ovr_q, rx_ovr_d, rx_clear_q, rx_clear_d;
  logic             rx_in_valid, rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]       rx_in_byte;

  `ifdef UART_LOOPBACK_EN
  assign rx_in_valid = lb_push;
  assign rx_in_byte  = tx_data_q;
  assign rx_clear_d  = 1'b0;
  `else
  // The clear pulse blocks a second take while the receiver is still dropping its byte.
  assign rx_in_valid = rx_ready_i & ~rx_clear_q;
  assign rx_in_byte  = rx_data_i;
  assign rx_clear_d  = rx_in_valid;
  `endif

  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_push  = rx_in_valid & ~rx_full;
  assign rx_pop   = rd_data & act & ~rx_empty;

  always_comb begin
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    rx_ovr_d  = rx_ovr_q;
    if (rx_push) begin
      rx_mem_d[rx_wptr_q] = rx_in_byte;
      rx_wptr_d           = rx_wptr_q + PTR_W'(1);
    end
    if (rx_pop) rx_rptr_d = rx_rptr_q + PTR_W'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_W'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_W'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    if (rx_in_valid & rx_full)  rx_ovr_d = 1'b1;
    else if (rd_stat & act)     rx_ovr_d = 1'b0;
  end

  assign rx_clear_o = rx_clear_q;

  always_comb begin
    uart_rdata_o = '0;
    if (rd_data && !rx_empty) uart_rdata_o = {24'b0, rx_mem_q[rx_rptr_q]};
    else if (rd_stat)         uart_rdata_o = {29'b0, rx_ovr_q, ~rx_empty, ~tx_full};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      tx_data_q  <= '0;
      state_q    <= TX_IDLE;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      rx_ovr_q   <= 1'b0;
      rx_clear_q <= 1'b0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_data_q  <= tx_data_d;
      state_q    <= state_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_clear_q <= rx_clear_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the counts alone decide which entries are valid.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
- Memory-mapped UART register block downstream of the data-memory controller. It decodes the same MEM-stage request bus and services the two UART addresses.
- Read data is combinational, so the controller completes UART accesses with zero stall.
- Buffers outgoing bytes in a TX FIFO drained to the serial transmitter by a small FSM. Buffers incoming bytes from the serial receiver in an RX FIFO.

Parameters:
- FIFO_DEPTH, 4, entries per FIFO; power of two, >= 2.
- DATA_ADDR, 32'hbfd003f8, data register address.
- STAT_ADDR, 32'hbfd003fc, status register address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_addr_i  in  32  access address
- mem_data_i  in  32  write data; byte [7:0] used
- mem_we_n_i  in  1  write enable, active low
- mem_oe_n_i  in  1  read enable, active low
- mem_be_n_i  in  4  byte enables, active low
- mem_ce_n_i  in  1  chip enable, active low
- stall_i  in  1  pipeline stall; suppresses all register side effects
- uart_rdata_o  out  32  combinational read data
- tx_data_o  out  8  byte to transmitter
- tx_start_o  out  1  one-cycle start pulse to transmitter
- tx_busy_i  in  1  transmitter busy
- rx_data_i  in  8  received byte
- rx_ready_i  in  1  receiver holds a valid byte
- rx_clear_o  out  1  one-cycle acknowledge; receiver drops its byte

Behaviour:
- Decode:
  - rd_data = ~ce_n & ~oe_n & addr==DATA_ADDR
  - rd_stat = ~ce_n & ~oe_n & addr==STAT_ADDR
  - wr_data = ~ce_n & ~we_n & ~be_n[0] & addr==DATA_ADDR
  - Writes to STAT_ADDR are ignored.
  - Side effects (push, pop, overrun clear) occur only on a clock edge with stall_i=0. A request held for N unstalled cycles acts N times.
- Read mux (combinational):
  - rd_data: {24'b0, RX head byte}, or 0 if RX is empty.
  - rd_stat: {29'b0, rx_ovr, rx_nonempty, tx_notfull}.
  - Otherwise 0.
- TX FIFO:
  - wr_data pushes mem_data_i[7:0] if not full; if full, the byte is dropped silently.
  - A push and an FSM pop in the same cycle are both performed; count is unchanged.
- TX FSM, states IDLE/START/GUARD:
  - IDLE -> START when the FIFO is nonempty and tx_busy_i=0. On that edge the head byte is popped into tx_data_o.
  - START: tx_start_o=1 for exactly one cycle, then -> GUARD.
  - GUARD: wait one cycle (transmitter raises busy), then -> IDLE.
  - tx_data_o holds its value until the next START.
- RX path:
  - When rx_ready_i=1 and rx_clear_o was not asserted the previous cycle, push rx_data_i and pulse rx_clear_o for one cycle.
  - If the RX FIFO is full: still pulse rx_clear_o, drop the byte, and set sticky rx_ovr.
  - rd_data pops the RX head if nonempty; popping an empty FIFO is a no-op.
  - rd_stat clears rx_ovr. If an overrun occurs in the same cycle, the set wins.
  - A simultaneous RX push and CPU pop are both performed.
- Pointers: log2(FIFO_DEPTH) bits each plus a count of log2(FIFO_DEPTH)+1 bits; pointers wrap modulo depth.
- Reset values:
  - Both FIFOs empty; FSM IDLE; rx_ovr=0.
  - tx_data_o=0, tx_start_o=0, rx_clear_o=0.
  - uart_rdata_o follows decode (status reads 32'h1).
  - Reset mid-transmit discards FIFO contents. The transmitter core is not aborted.

Optional Feature:
- UART_LOOPBACK_EN defined:
  - Bytes launched by the TX FSM (START cycle) are pushed into the RX FIFO instead of driving the transmitter. tx_start_o stays 0.
  - rx_ready_i is ignored and rx_clear_o stays 0.
  - An RX-full overrun still sets rx_ovr.
- Undefined: behaviour as above.

Test Plan:
- Reset, then read STAT_ADDR -> uart_rdata_o=32'h00000001. Read DATA_ADDR -> 32'h0.
- Write 0x41, 0x42 to DATA_ADDR with tx_busy_i=0 -> tx_start_o pulses twice, tx_data_o=0x41 then 0x42, at least 3 cycles apart.
- Hold tx_busy_i=1 and write 5 bytes (depth 4) -> status bit0=0 after the 4th; the 5th is dropped. Release busy -> exactly 4 bytes sent, in order.
- rx_ready_i with 0x5A -> one rx_clear_o pulse; status=32'h3. Read DATA -> 32'h5A; status back to 32'h1.
- Push 5 RX bytes without reading -> status bit2=1. Read status -> clears (next read 32'h3). Data reads return the first 4 bytes.
- Read DATA with stall_i=1 for 3 cycles, then stall_i=0 for 1 cycle -> exactly one pop.
